// File: rtl/inv_mixcolumn_iter.sv
// AES InvMixColumns over a 128-bit state, one 32-bit column per cycle.
// Accept->out_valid in 4 cycles; result held in DONE until out_ready, new state may be accepted on the retire edge.
module inv_mixcolumn_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] data_in,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] data_out,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_data;
  logic [31:0]  w_col;
  logic [31:0]  w_col_inv;
  logic [127:0] w_data_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e products are assembled from the x2/x4/x8 chain of each byte
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] b [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = c[8*i +: 8];
      m2[i] = xtime(b[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m9[i] = m8[i] ^ b[i];
      mb[i] = m8[i] ^ m2[i] ^ b[i];
      md[i] = m8[i] ^ m4[i] ^ b[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

  always_comb begin
    w_col       = r_data[127:96];
    w_data_next = r_data;
    case (r_cnt)
      2'd0: w_col = r_data[127:96];
      2'd1: w_col = r_data[95:64];
      2'd2: w_col = r_data[63:32];
      default: w_col = r_data[31:0];
    endcase
    w_col_inv = inv_col(w_col);
    case (r_cnt)
      2'd0: w_data_next[127:96] = w_col_inv;
      2'd1: w_data_next[95:64]  = w_col_inv;
      2'd2: w_data_next[63:32]  = w_col_inv;
      default: w_data_next[31:0] = w_col_inv;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC);
  assign data_out  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_data  <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= data_in;
            r_cnt   <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_data <= w_data_next;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= S_DONE;
        end
        S_DONE: begin
          // retire and accept can share one edge for back-to-back states
          if (out_ready) begin
            if (in_valid) begin
              r_data  <= data_in;
              r_cnt   <= 2'd0;
              r_state <= S_CALC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// Directed and round-trip bench for inv_mixcolumn_iter with a queue scoreboard.
`timescale 1ns/1ps
module tb_inv_mixcolumn_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] data_in;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] data_out;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] V1_IN  = 128'hbca14d8e_9d58dc9f_c6c6c6c6_d6d7d5d5;
  localparam logic [127:0] V1_EXP = 128'h455313db_5c220af2_c6c6c6c6_d5d4d4d4;
  localparam logic [127:0] ONES   = {4{32'h01010101}};

  inv_mixcolumn_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // forward MixColumns: the bench feeds fwd(x) and expects x back
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] b1, b2, b3, b4;
    b1 = c[7:0]; b2 = c[15:8]; b3 = c[23:16]; b4 = c[31:24];
    return {xt(b1) ^ b1 ^ b2 ^ b3 ^ xt(b4),
            b1 ^ b2 ^ xt(b3) ^ xt(b4) ^ b4,
            b1 ^ xt(b2) ^ xt(b3) ^ b3 ^ b4,
            xt(b1) ^ xt(b2) ^ b2 ^ b3 ^ b4};
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] x);
    return {fwd_col(x[127:96]), fwd_col(x[95:64]), fwd_col(x[63:32]), fwd_col(x[31:0])};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_output", 128'(out_valid), 128'd0);
      else chk("sb_data", data_out, sb_q.pop_front());
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(in_ready), 128'd1);
  endtask

  task automatic send(input logic [127:0] din, input logic [127:0] exp, input string tag);
    data_in  = din;
    in_valid = 1'b1;
    wait_ready(tag);
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    tick();
    chk(tag, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] xa, xb, xv;
    int n;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    tick();
    tick();

    // release with a state already offered: first edge accepts it
    rst_n    = 1'b1;
    in_valid = 1'b1;
    data_in  = V1_IN;
    sb_q.push_back(V1_EXP);
    chk("v1_in_ready", 128'(in_ready), 128'd1);
    tick();
    chk("v1_busy", 128'(busy), 128'd1);
    chk("v1_in_ready_calc", 128'(in_ready), 128'd0);
    data_in = rnd128();
    tick();
    chk("v1_ov_e1", 128'(out_valid), 128'd0);
    data_in = rnd128();
    tick();
    chk("v1_ov_e2", 128'(out_valid), 128'd0);
    in_valid = 1'b0;
    data_in  = rnd128();
    tick();
    chk("v1_ov_e3", 128'(out_valid), 128'd0);
    tick();
    chk("v1_ov_e4", 128'(out_valid), 128'd1);
    chk("v1_data", data_out, V1_EXP);
    chk("v1_busy_done", 128'(busy), 128'd0);
    tick();
    chk("v1_pulse", 128'(out_valid), 128'd0);
    chk("v1_drained", 128'(sb_q.size()), 128'd0);

    send(128'd0, 128'd0, "zero_send");
    drain(20, "zero_drain");
    send(ONES, ONES, "ones_send");
    drain(20, "ones_drain");

    // backpressure in DONE
    out_ready = 1'b0;
    send(V1_IN, V1_EXP, "bp_send");
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      data_in  = rnd128();
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_data", data_out, V1_EXP);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_retired", 128'(out_valid), 128'd0);
    chk("bp_single", 128'(sb_q.size()), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_no_repeat", 128'(out_valid), 128'd0);
    end

    // back-to-back with in_valid held
    xa = rnd128();
    xb = rnd128();
    data_in  = fwd(xa);
    in_valid = 1'b1;
    wait_ready("b2b_ready_a");
    sb_q.push_back(xa);
    tick();
    data_in = fwd(xb);
    sb_q.push_back(xb);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_a_valid", 128'(out_valid), 128'd1);
    chk("b2b_ready_b", 128'(in_ready), 128'd1);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        chk("b2b_b_busy", 128'(busy), 128'd1);
      end
    end while (!out_valid && n < 20);
    chk("b2b_spacing", 128'(n), 128'd5);
    drain(20, "b2b_drain");

    // reset while the column counter is 2
    xv = rnd128();
    data_in  = fwd(xv);
    in_valid = 1'b1;
    wait_ready("rst_mid_ready");
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_busy_pre", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", 128'(out_valid), 128'd0);
    chk("rst_mid_data", data_out, 128'd0);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_mid_no_stale", 128'(out_valid), 128'd0);
    end
    send(fwd(xv), xv, "rst_mid_next");
    drain(20, "rst_mid_drain");

    // round trip, streamed back-to-back
    for (int i = 0; i < 10000; i++) begin
      xv = rnd128();
      data_in  = fwd(xv);
      in_valid = 1'b1;
      wait_ready("rt_ready");
      sb_q.push_back(xv);
      tick();
    end
    in_valid = 1'b0;
    drain(40, "rt_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
